// File: rtl/mem_load_unit.sv
// mem_load_unit: fetches a byte, halfword or word from word-organised memory,
// splitting accesses that straddle a word boundary into two reads, and returns
// the value sign- or zero-extended with a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new load; start latches the request
// REQ0  | reading the word that holds the first byte
// REQ1  | reading the following word (split accesses only)
// DONE  | loaded is valid, done pulses for this single cycle
module mem_load_unit #(
  parameter int XLEN = 32,
  parameter int MEM_TYPE_LEN = 2,
  parameter logic [MEM_TYPE_LEN-1:0] MEM_B = MEM_TYPE_LEN'(0),
  parameter logic [MEM_TYPE_LEN-1:0] MEM_H = MEM_TYPE_LEN'(1),
  parameter logic [MEM_TYPE_LEN-1:0] MEM_W = MEM_TYPE_LEN'(2)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [XLEN-1:0]         addr,
  input  logic [MEM_TYPE_LEN-1:0] load_type,
  input  logic                    load_unsigned,
  output logic                    ready,
  output logic                    mem_req,
  output logic [XLEN-1:0]         mem_addr,
  input  logic                    mem_valid,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic                    done,
  output logic [XLEN-1:0]         loaded
);

  typedef enum logic [1:0] {S_IDLE, S_REQ0, S_REQ1, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t          state_q, state_d;
  size_t           sz_q, sz_d;
  logic [1:0]      off_q, off_d;
  logic            uns_q, uns_d;
  logic            split_q, split_d;
  logic [XLEN-1:0] word0_q, word0_d;
  logic            ready_q, ready_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] loaded_q, loaded_d;

  // Extraction operands: the low word is the latched first read when the
  // second read is arriving, otherwise the word arriving right now.
  logic [XLEN-1:0] ext_lo, ext_hi, ext_raw, ext_val;
  size_t           req_sz;
  logic            req_split;

  // Align and extend the requested bytes from the current word pair.
  always_comb begin
    ext_lo  = (state_q == S_REQ1) ? word0_q : mem_rdata;
    ext_hi  = (state_q == S_REQ1) ? mem_rdata : '0;
    ext_raw = XLEN'({ext_hi, ext_lo} >> {off_q, 3'b000});
    case (sz_q)
      SZ_B:    ext_val = {{(XLEN-8){ext_raw[7] & ~uns_q}}, ext_raw[7:0]};
      SZ_H:    ext_val = {{(XLEN-16){ext_raw[15] & ~uns_q}}, ext_raw[15:0]};
      default: ext_val = ext_raw;
    endcase
  end

  // Decode the incoming access size and whether it crosses a word boundary.
  always_comb begin
    if (load_type == MEM_B) begin
      req_sz = SZ_B;
    end else if (load_type == MEM_H) begin
      req_sz = SZ_H;
    end else begin
      req_sz = SZ_W;
    end
    case (req_sz)
      SZ_B:    req_split = 1'b0;
      SZ_H:    req_split = (addr[1:0] == 2'd3);
      default: req_split = (addr[1:0] != 2'd0);
    endcase
  end

  // Next-state and next-output logic; outputs are registered from next state.
  always_comb begin
    state_d    = state_q;
    sz_d       = sz_q;
    off_d      = off_q;
    uns_d      = uns_q;
    split_d    = split_q;
    word0_d    = word0_q;
    mem_addr_d = mem_addr_q;
    loaded_d   = loaded_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sz_d       = req_sz;
          off_d      = addr[1:0];
          uns_d      = load_unsigned;
          split_d    = req_split;
          mem_addr_d = {addr[XLEN-1:2], 2'b00};
          state_d    = S_REQ0;
        end
      end
      S_REQ0: begin
        if (mem_valid) begin
          word0_d = mem_rdata;
          if (split_q) begin
            // Word address wraps past the top of memory back to zero.
            mem_addr_d = mem_addr_q + XLEN'(4);
            state_d    = S_REQ1;
          end else begin
            loaded_d = ext_val;
            state_d  = S_DONE;
          end
        end
      end
      S_REQ1: begin
        if (mem_valid) begin
          loaded_d = ext_val;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d   = (state_d == S_IDLE);
    mem_req_d = (state_d == S_REQ0) || (state_d == S_REQ1);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sz_q       <= SZ_W;
      off_q      <= 2'd0;
      uns_q      <= 1'b0;
      split_q    <= 1'b0;
      word0_q    <= '0;
      ready_q    <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      loaded_q   <= '0;
    end else begin
      state_q    <= state_d;
      sz_q       <= sz_d;
      off_q      <= off_d;
      uns_q      <= uns_d;
      split_q    <= split_d;
      word0_q    <= word0_d;
      ready_q    <= ready_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
      loaded_q   <= loaded_d;
    end
  end

  assign ready    = ready_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign done     = done_q;
  assign loaded   = loaded_q;

endmodule
